sprite_palette_ram: RTL and testbench

//  Writable, multi-bank sprite colour lookup with a global fade effect. Maps a
//  per-pixel palette index plus a bank select to 4:4:4 RGB for the VGA colour

---
 rtl/sprite_palette_ram.sv | 126 ++++++++++++
 tb/tb_sprite_palette_ram.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_palette_ram.sv
// rtl/sprite_palette_ram.sv - banked writable sprite palette with 2-stage lookup and global fade-to-black
module sprite_palette_ram #(
  parameter int INDEX_W   = 5,
  parameter int NUM_BANKS = 4,
  parameter int CH_W      = 4,
  parameter int FADE_DIV  = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_BANKS)-1:0] wr_bank,
  input  logic [INDEX_W-1:0]           wr_index,
  input  logic [3*CH_W-1:0]            wr_rgb,
  input  logic                         rd_valid_in,
  input  logic [$clog2(NUM_BANKS)-1:0] bank_sel,
  input  logic [INDEX_W-1:0]           index,
  input  logic                         frame_tick,
  input  logic                         fade_start,
  input  logic                         fade_dir,
  output logic [CH_W-1:0]              red,
  output logic [CH_W-1:0]              green,
  output logic [CH_W-1:0]              blue,
  output logic                         rd_valid_out,
  output logic                         transparent,
  output logic                         fade_busy
);

  localparam int WORD_W = 3 * CH_W;
  localparam int DEPTH  = NUM_BANKS * (2 ** INDEX_W);
  localparam int DIV_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [CH_W-1:0]  DIM_MAX  = '1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIV - 1);

  typedef enum logic [1:0] {FADE_IDLE, FADE_OUT, FADE_IN} fade_state_t;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] s1_word;
  logic              s1_valid;
  logic              s1_transp;

  fade_state_t       state, state_n;
  logic [DIV_W-1:0]  div, div_n;
  logic [CH_W-1:0]   dim, dim_n;

  function automatic logic [CH_W-1:0] sat_sub(input logic [CH_W-1:0] c, input logic [CH_W-1:0] d);
    return (c > d) ? c - d : '0;
  endfunction

  // RAM is deliberately outside the reset domain so palettes survive a level reset.
  always_ff @(posedge Clk) begin
    if (wr_en)
      mem[{wr_bank, wr_index}] <= wr_rgb;
  end

  // Read-before-write: a same-cycle write to the looked-up entry returns the old word.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_word   <= '0;
      s1_valid  <= 1'b0;
      s1_transp <= 1'b0;
    end else begin
      s1_word   <= mem[{bank_sel, index}];
      s1_valid  <= rd_valid_in;
      s1_transp <= (index == '0);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      red          <= '0;
      green        <= '0;
      blue         <= '0;
      rd_valid_out <= 1'b0;
      transparent  <= 1'b0;
    end else begin
      red          <= sat_sub(s1_word[3*CH_W-1 -: CH_W], dim);
      green        <= sat_sub(s1_word[2*CH_W-1 -: CH_W], dim);
      blue         <= sat_sub(s1_word[CH_W-1   -: CH_W], dim);
      rd_valid_out <= s1_valid;
      transparent  <= s1_transp;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= FADE_IDLE;
      div   <= '0;
      dim   <= '0;
    end else begin
      state <= state_n;
      div   <= div_n;
      dim   <= dim_n;
    end
  end

  // A start/redirect swallows any frame_tick in the same cycle and keeps the current dim.
  always_comb begin
    state_n = state;
    div_n   = div;
    dim_n   = dim;
    if (fade_start) begin
      state_n = fade_dir ? FADE_OUT : FADE_IN;
      div_n   = '0;
    end else if (frame_tick && state != FADE_IDLE) begin
      if (div == DIV_LAST) begin
        div_n = '0;
        if (state == FADE_OUT) begin
          if (dim != DIM_MAX)
            dim_n = dim + CH_W'(1);
          if (dim_n == DIM_MAX)
            state_n = FADE_IDLE;
        end else begin
          if (dim != '0)
            dim_n = dim - CH_W'(1);
          if (dim_n == '0)
            state_n = FADE_IDLE;
        end
      end else begin
        div_n = div + DIV_W'(1);
      end
    end
  end

  assign fade_busy = (state != FADE_IDLE);

endmodule

// File: tb/tb_sprite_palette_ram.sv
// tb/tb_sprite_palette_ram.sv - randomized self-checking bench for sprite_palette_ram against a palette/fade model
module tb_sprite_palette_ram;

  localparam int FADE_DIV = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_bank = '0;
  logic [4:0]  wr_index = '0;
  logic [11:0] wr_rgb = '0;
  logic        rd_valid_in = 1'b0;
  logic [1:0]  bank_sel = '0;
  logic [4:0]  index = '0;
  logic        frame_tick = 1'b0;
  logic        fade_start = 1'b0;
  logic        fade_dir = 1'b0;
  logic [3:0]  red, green, blue;
  logic        rd_valid_out, transparent, fade_busy;

  sprite_palette_ram dut (
    .Clk(Clk), .Reset(Reset),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index), .wr_rgb(wr_rgb),
    .rd_valid_in(rd_valid_in), .bank_sel(bank_sel), .index(index),
    .frame_tick(frame_tick), .fade_start(fade_start), .fade_dir(fade_dir),
    .red(red), .green(green), .blue(blue),
    .rd_valid_out(rd_valid_out), .transparent(transparent), .fade_busy(fade_busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // Reference model: palette contents, fade mode/level, and the lookup in flight.
  logic [11:0] mem_m [128];
  int          dim_m = 0;
  int          mode_m = 0;   // 0 idle, 1 darkening, 2 brightening
  int          ticks_m = 0;
  logic [11:0] p_word = '0;
  bit          p_valid = 0, p_t = 0;
  logic [11:0] e_rgb = '0;
  bit          e_valid = 0, e_t = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] dimmed(input logic [11:0] w, input int d);
    int r, g, b;
    r = int'(w[11:8]) - d; if (r < 0) r = 0;
    g = int'(w[7:4])  - d; if (g < 0) g = 0;
    b = int'(w[3:0])  - d; if (b < 0) b = 0;
    return {4'(r), 4'(g), 4'(b)};
  endfunction

  task automatic step();
    @(posedge Clk);
    if (Reset) begin
      e_rgb = '0; e_valid = 0; e_t = 0;
      p_word = '0; p_valid = 0; p_t = 0;
      dim_m = 0; mode_m = 0; ticks_m = 0;
    end else begin
      e_rgb   = dimmed(p_word, dim_m);
      e_valid = p_valid;
      e_t     = p_t;
      p_word  = mem_m[int'(bank_sel) * 32 + int'(index)];
      p_valid = rd_valid_in;
      p_t     = (index == 0);
      if (fade_start) begin
        mode_m  = fade_dir ? 1 : 2;
        ticks_m = 0;
      end else if (frame_tick && mode_m != 0) begin
        ticks_m++;
        if (ticks_m % FADE_DIV == 0) begin
          if (mode_m == 1) begin
            if (dim_m < 15) dim_m++;
            if (dim_m == 15) mode_m = 0;
          end else begin
            if (dim_m > 0) dim_m--;
            if (dim_m == 0) mode_m = 0;
          end
        end
      end
    end
    if (wr_en) mem_m[int'(wr_bank) * 32 + int'(wr_index)] = wr_rgb;
    #1;
    check("rd_valid_out", rd_valid_out, e_valid);
    check("transparent", transparent, e_t);
    check("rgb", {red, green, blue}, e_rgb);
    check("fade_busy", fade_busy, (mode_m != 0));
    Reset = 0; wr_en = 0; rd_valid_in = 0; frame_tick = 0; fade_start = 0;
  endtask

  task automatic write(input int b, input int i, input logic [11:0] d);
    wr_en = 1; wr_bank = 2'(b); wr_index = 5'(i); wr_rgb = d;
    step();
  endtask

  task automatic lookup(input int b, input int i);
    rd_valid_in = 1; bank_sel = 2'(b); index = 5'(i);
    step();
    step();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1;
      step();
      step();
    end
  endtask

  initial begin
    for (int a = 0; a < 128; a++) mem_m[a] = '0;
    step();
    check("reset_rgb", {red, green, blue}, 0);
    check("reset_busy", fade_busy, 0);

    write(2, 7, 12'hFE1);
    lookup(2, 7);
    check("t1_rgb", {red, green, blue}, 12'hFE1);
    check("t1_valid", rd_valid_out, 1);
    check("t1_transp", transparent, 0);
    lookup(1, 7);
    check("t1_bank1_untouched", {red, green, blue}, 0);

    write(3, 0, 12'h5A5);
    write(3, 1, 12'h777);
    lookup(3, 0);
    check("t2_transp_idx0", transparent, 1);
    check("t2_rgb_idx0", {red, green, blue}, 12'h5A5);
    lookup(3, 1);
    check("t2_transp_idx1", transparent, 0);

    write(0, 3, 12'hAB2);
    wr_en = 1; wr_bank = 0; wr_index = 3; wr_rgb = 12'h123;
    rd_valid_in = 1; bank_sel = 0; index = 3;
    step();
    step();
    check("t3_old_word", {red, green, blue}, 12'hAB2);
    lookup(0, 3);
    check("t3_new_word", {red, green, blue}, 12'h123);

    fade_start = 1; fade_dir = 1;
    step();
    ticks(4);
    lookup(2, 7);
    check("t4_dim1", {red, green, blue}, 12'hED0);
    ticks(56);
    lookup(2, 7);
    check("t4_black", {red, green, blue}, 0);
    check("t4_busy_low", fade_busy, 0);
    ticks(8);
    lookup(2, 7);
    check("t4_held_black", {red, green, blue}, 0);

    Reset = 1; step();
    fade_start = 1; fade_dir = 1; step();
    ticks(24);
    fade_start = 1; fade_dir = 0; frame_tick = 1; step();
    lookup(2, 7);
    check("t5_no_step_on_redirect", {red, green, blue}, 12'h980);
    ticks(4);
    lookup(2, 7);
    check("t5_dim5", {red, green, blue}, 12'hA90);
    ticks(20);
    lookup(2, 7);
    check("t5_dim0", {red, green, blue}, 12'hFE1);
    check("t5_busy_low", fade_busy, 0);

    fade_start = 1; fade_dir = 1; step();
    ticks(36);
    rd_valid_in = 1; bank_sel = 2; index = 7; step();
    rd_valid_in = 1; bank_sel = 3; index = 0; step();
    Reset = 1; step();
    check("t6_rgb_zero", {red, green, blue}, 0);
    check("t6_valid_zero", rd_valid_out, 0);
    check("t6_transp_zero", transparent, 0);
    check("t6_busy_zero", fade_busy, 0);
    lookup(2, 7);
    check("t6_ram_kept_a", {red, green, blue}, 12'hFE1);
    lookup(0, 3);
    check("t6_ram_kept_b", {red, green, blue}, 12'h123);

    for (int n = 0; n < 4000; n++) begin
      wr_en       = ($urandom % 3 == 0);
      wr_bank     = 2'($urandom_range(3));
      wr_index    = 5'($urandom_range(31));
      wr_rgb      = 12'($urandom);
      rd_valid_in = $urandom % 2;
      bank_sel    = ($urandom % 4 == 0) ? wr_bank : 2'($urandom_range(3));
      index       = ($urandom % 4 == 0) ? wr_index : (($urandom % 6 == 0) ? 5'd0 : 5'($urandom_range(31)));
      frame_tick  = ($urandom % 3 == 0);
      fade_start  = ($urandom % 90 == 0);
      fade_dir    = $urandom % 2;
      Reset       = ($urandom % 700 == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
